branch_rs: RTL

- Reservation station for conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Accepts dispatched branches from the decoder and snoops the CDB for pending source operands.
- Each cycle, issues at most one operand-complete entry, as a registered operand packet, to the branch ALU.
- Sits between the dispatch stage and the branch ALU. It is the producing end of the ALU's valid/vi/vj/imm/op/pc/rob_entry input interface.

---
 rtl/branch_rs.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/branch_rs.sv
// Branch reservation station: dispatch/CDB-snoop into RS_SIZE slots; issues one ready entry per edge (registered, >=1 edge after completion).
// Backpressure: rs_full must gate dispatch (dispatch while full is dropped); rdy_in low freezes all state and outputs.
module branch_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_in,
  input  logic               disp_valid,
  input  logic [2:0]         disp_op,
  input  logic [11:0]        disp_imm,
  input  logic [31:0]        disp_pc,
  input  logic [ROB_BIT-1:0] disp_rob_entry,
  input  logic               disp_qj_busy,
  input  logic [ROB_BIT-1:0] disp_qj,
  input  logic [31:0]        disp_vj,
  input  logic               disp_qk_busy,
  input  logic [ROB_BIT-1:0] disp_qk,
  input  logic [31:0]        disp_vk,
  input  logic               cdb_valid,
  input  logic [ROB_BIT-1:0] cdb_rob_entry,
  input  logic [31:0]        cdb_value,
  output logic               rs_full,
  output logic               alu_valid,
  output logic [31:0]        alu_vi,
  output logic [31:0]        alu_vj,
  output logic [11:0]        alu_imm,
  output logic [2:0]         alu_op,
  output logic [31:0]        alu_pc,
  output logic [ROB_BIT-1:0] alu_rob_entry
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [2:0]         op;
    logic [11:0]        imm;
    logic [31:0]        pc;
    logic [ROB_BIT-1:0] rob_entry;
    logic               qj_busy;
    logic [ROB_BIT-1:0] qj;
    logic [31:0]        vj;
    logic               qk_busy;
    logic [ROB_BIT-1:0] qk;
    logic [31:0]        vk;
  } entry_t;

  logic [RS_SIZE-1:0] busy;
  entry_t             ent [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic               iss_found;
  logic [IDX_W-1:0]   iss_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               fwd_j;
  logic               fwd_k;
  logic               do_disp;
  entry_t             new_ent;

  assign rs_full = &busy;
  assign do_disp = disp_valid && !rs_full;

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    ready     = '0;
    iss_found = 1'b0;
    iss_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy[i] && !ent[i].qj_busy && !ent[i].qk_busy;
      if (ready[i]) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // A tag broadcast in the dispatch cycle would otherwise be missed forever.
  always_comb begin
    fwd_j             = disp_qj_busy && cdb_valid && (disp_qj == cdb_rob_entry);
    fwd_k             = disp_qk_busy && cdb_valid && (disp_qk == cdb_rob_entry);
    new_ent.op        = disp_op;
    new_ent.imm       = disp_imm;
    new_ent.pc        = disp_pc;
    new_ent.rob_entry = disp_rob_entry;
    new_ent.qj_busy   = disp_qj_busy && !fwd_j;
    new_ent.qj        = disp_qj;
    new_ent.vj        = fwd_j ? cdb_value : disp_vj;
    new_ent.qk_busy   = disp_qk_busy && !fwd_k;
    new_ent.qk        = disp_qk;
    new_ent.vk        = fwd_k ? cdb_value : disp_vk;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy          <= '0;
      alu_valid     <= 1'b0;
      alu_vi        <= '0;
      alu_vj        <= '0;
      alu_imm       <= '0;
      alu_op        <= '0;
      alu_pc        <= '0;
      alu_rob_entry <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        if (cdb_valid) begin
          for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && ent[i].qj_busy && ent[i].qj == cdb_rob_entry) begin
              ent[i].qj_busy <= 1'b0;
              ent[i].vj      <= cdb_value;
            end
            if (busy[i] && ent[i].qk_busy && ent[i].qk == cdb_rob_entry) begin
              ent[i].qk_busy <= 1'b0;
              ent[i].vk      <= cdb_value;
            end
          end
        end
        // Issue decision uses pre-edge readiness, so wakeups land one edge later.
        if (iss_found) begin
          alu_valid     <= 1'b1;
          alu_vi        <= ent[iss_idx].vj;
          alu_vj        <= ent[iss_idx].vk;
          alu_imm       <= ent[iss_idx].imm;
          alu_op        <= ent[iss_idx].op;
          alu_pc        <= ent[iss_idx].pc;
          alu_rob_entry <= ent[iss_idx].rob_entry;
          busy[iss_idx] <= 1'b0;
        end else begin
          alu_valid <= 1'b0;
        end
        if (do_disp) begin
          busy[free_idx] <= 1'b1;
          ent[free_idx]  <= new_ent;
        end
      end
    end
  end

endmodule
